// File: rtl/returnstack.sv
// returnstack: hardware return-address stack for the CPU sequencer.
// A call pushes the return address; a return pops it and the sequencer
// samples 'top' in the same cycle it asserts 'pop'.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   push       store push_addr on this edge (call)
//   pop        remove the top entry on this edge (return)
//   push_addr  return address to store
//   clear_err  clears the sticky overflow/underflow flags
//   top        current top-of-stack address, 0 when empty
//   count      number of valid entries, 0..depth
//   empty      count == 0
//   full       count == depth
//   overflow   sticky: push made while full
//   underflow  sticky: pop made while empty
//
// Build option: RETURNSTACK_WRAP_EN -- when defined, a push while full
// overwrites the oldest entry; otherwise the push is dropped.
module returnstack #(
  parameter int addr_width = 9,
  parameter int depth      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [addr_width-1:0]       push_addr,
  input  logic                        clear_err,
  output logic [addr_width-1:0]       top,
  output logic [$clog2(depth):0]      count,
  output logic                        empty,
  output logic                        full,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int spw = $clog2(depth);
  localparam int cw  = spw + 1;
  localparam logic [cw-1:0] full_cnt = cw'(depth);

  logic [addr_width-1:0] mem [depth];
  logic [spw-1:0]        sp, sp_nxt, wr_idx;
  logic [cw-1:0]         cnt, cnt_nxt;
  logic                  wr_en, ovf_evt, unf_evt;

  assign empty = (cnt == '0);
  assign full  = (cnt == full_cnt);
  assign count = cnt;
  // Registered state only; no path from push/pop/push_addr.
  assign top   = empty ? '0 : mem[sp - 1'b1];

  always_comb begin
    sp_nxt  = sp;
    cnt_nxt = cnt;
    wr_en   = 1'b0;
    wr_idx  = sp;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (push && pop && !empty) begin
      // Tail call: replace the top entry in place.
      wr_en  = 1'b1;
      wr_idx = sp - 1'b1;
    end else if (push) begin
      // Covers push-only and push+pop on an empty stack.
      if (!full) begin
        wr_en   = 1'b1;
        sp_nxt  = sp + 1'b1;
        cnt_nxt = cnt + 1'b1;
      end else begin
        ovf_evt = 1'b1;
`ifdef RETURNSTACK_WRAP_EN
        // Oldest entry sits at sp when full; overwrite it and advance.
        wr_en  = 1'b1;
        sp_nxt = sp + 1'b1;
`endif
      end
    end else if (pop) begin
      if (!empty) begin
        sp_nxt  = sp - 1'b1;
        cnt_nxt = cnt - 1'b1;
      end else begin
        unf_evt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp        <= '0;
      cnt       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp  <= sp_nxt;
      cnt <= cnt_nxt;
      if (ovf_evt)        overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (unf_evt)        underflow <= 1'b1;
      else if (clear_err) underflow <= 1'b0;
    end
  end

  // Storage is not reset; 'top' is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= push_addr;
  end

endmodule

// File: tb/tb_returnstack.sv
module tb_returnstack;

  localparam int AW = 9;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          push, pop, clear_err;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] top;
  logic [3:0]    count;
  logic          empty, full, overflow, underflow;

  returnstack #(.addr_width(AW), .depth(D)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .push_addr(push_addr), .clear_err(clear_err),
    .top(top), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] top;
    logic [3:0]    count;
    logic          empty, full, ovf, unf;
  } exp_t;

  exp_t       expq[$];
  int         model[$];
  logic       movf, munf;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.top   = (model.size() > 0) ? AW'(model[$]) : '0;
    e.count = 4'(model.size());
    e.empty = (model.size() == 0);
    e.full  = (model.size() == D);
    e.ovf   = movf;
    e.unf   = munf;
    return e;
  endfunction

  task automatic check_state(input string tag);
    exp_t e;
    e = expq.pop_front();
    chk({tag, ".top"},   32'(top),       32'(e.top));
    chk({tag, ".count"}, 32'(count),     32'(e.count));
    chk({tag, ".empty"}, 32'(empty),     32'(e.empty));
    chk({tag, ".full"},  32'(full),      32'(e.full));
    chk({tag, ".ovf"},   32'(overflow),  32'(e.ovf));
    chk({tag, ".unf"},   32'(underflow), 32'(e.unf));
  endtask

  // One clocked operation: drive, predict, then compare after the edge.
  task automatic step(input string tag, input logic p, input logic q,
                      input logic [AW-1:0] a, input logic clr);
    logic oe, ue;
    @(negedge clk);
    push = p; pop = q; push_addr = a; clear_err = clr;
    oe = 1'b0; ue = 1'b0;
    if (p && q && model.size() > 0) begin
      model[model.size()-1] = int'(a);
    end else if (p) begin
      if (model.size() < D) model.push_back(int'(a));
      else begin
        oe = 1'b1;
`ifdef RETURNSTACK_WRAP_EN
        void'(model.pop_front());
        model.push_back(int'(a));
`endif
      end
    end else if (q) begin
      if (model.size() > 0) void'(model.pop_back());
      else ue = 1'b1;
    end
    movf = oe ? 1'b1 : (clr ? 1'b0 : movf);
    munf = ue ? 1'b1 : (clr ? 1'b0 : munf);
    expq.push_back(snap());
    @(posedge clk);
    #1;
    check_state(tag);
    push = 1'b0; pop = 1'b0; clear_err = 1'b0; push_addr = '0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; clear_err = 1'b0; push_addr = '0;
    movf = 1'b0; munf = 1'b0;
    #12;
    expq.push_back(snap());
    check_state("reset");
    @(negedge clk);
    reset = 1'b0;

    step("push10", 1, 0, 9'h010, 0);
    step("push20", 1, 0, 9'h020, 0);
    step("push30", 1, 0, 9'h030, 0);
    step("pop1",   0, 1, 9'h000, 0);
    step("pop2",   0, 1, 9'h000, 0);
    step("pop3",   0, 1, 9'h000, 0);
    step("popempty", 0, 1, 9'h000, 0);
    step("clrunf", 0, 0, 9'h000, 1);
    step("push05", 1, 0, 9'h005, 0);
    step("tailcall", 1, 1, 9'h1FF, 0);
    step("pop_tc", 0, 1, 9'h000, 0);
    step("pp_empty", 1, 1, 9'h077, 0);
    step("pop_pp", 0, 1, 9'h000, 0);
    // Underflow event and clear_err in the same cycle: event wins.
    step("unf_clr", 0, 1, 9'h000, 1);
    step("clr2", 0, 0, 9'h000, 1);

    for (int i = 1; i <= 8; i++) step("fill", 1, 0, AW'(i), 0);
    step("push_full", 1, 0, 9'h0AA, 0);
    step("ovf_hold", 0, 0, 9'h000, 0);
    for (int i = 0; i < 8; i++) step("drain", 0, 1, 9'h000, 0);
    step("clrovf", 0, 0, 9'h000, 1);

    // Asynchronous reset between clock edges.
    step("push33", 1, 0, 9'h033, 0);
    step("unf_pre", 0, 0, 9'h000, 0);
    #2;
    reset = 1'b1;
    model.delete();
    movf = 1'b0; munf = 1'b0;
    #1;
    expq.push_back(snap());
    check_state("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 1, 0, 9'h044, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/returnstack.md
Name: returnstack

Overview:
- Hardware return-address stack for the CPU sequencer.
- The call path pushes the return address; the return path pops it and feeds it back as the next PC.
- It is the reverse direction of the relative branch target logic: branch logic computes where to go, this block stores and returns where to come back to.
- Sits beside the PC register; a single-cycle push or pop is issued per instruction.

Parameters:
- addr_width, 9, width of stored addresses (matches PC width).
- depth, 8, number of entries; must be a power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- push  input  1  store push_addr on this edge (call).
- pop  input  1  remove top entry on this edge (return).
- push_addr  input  addr_width  return address to store.
- clear_err  input  1  clears the sticky overflow/underflow flags.
- top  output  addr_width  current top-of-stack address; 0 when empty.
- count  output  clog2(depth)+1  number of valid entries, 0..depth.
- empty  output  1  count == 0.
- full  output  1  count == depth.
- overflow  output  1  sticky: a push was made while full.
- underflow  output  1  sticky: a pop was made while empty.

Behaviour:
- Reset (asynchronous, active-high): count=0, stack pointer=0, overflow=0, underflow=0, empty=1, full=0, top=0. Storage contents need not be cleared, but top must read 0 while empty.
- All state updates on the rising clk edge. top/count/empty/full reflect the new state in the cycle after the edge (1-cycle latency). top is driven combinationally from registered state only; it has no path from push/pop/push_addr.
- Storage: circular array indexed by sp, with sp wrapping modulo depth. top = mem[sp-1] when count>0.
- push only, not full: mem[sp] <= push_addr; sp <= sp+1; count <= count+1.
- pop only, not empty: sp <= sp-1; count <= count-1. The popped value is the top shown before the edge, so the sequencer samples top in the same cycle it asserts pop.
- push and pop together, count>0: replace the top entry (tail call). mem[sp-1] <= push_addr; sp and count unchanged.
- push and pop together, empty: behaves as push only. underflow is not set.
- push while full, no pop: see Optional Feature. overflow <= 1 in both builds.
- pop while empty, no push: no state change; underflow <= 1.
- clear_err: overflow <= 0 and underflow <= 0, unless a new overflow/underflow event occurs in the same cycle, in which case the event wins (flag = 1).
- Arithmetic: sp is clog2(depth) bits with natural wrap. count saturates at 0 and at depth and never wraps.
- Reset asserted mid-sequence: immediate return to the reset state regardless of push/pop.

Optional Feature:
- Macro: RETURNSTACK_WRAP_EN.
- Defined: push while full overwrites the oldest entry. mem[sp] <= push_addr; sp <= sp+1; count stays at depth; top becomes push_addr. Deep recursion therefore loses the oldest return addresses instead of the newest.
- Not defined: push while full is dropped. Storage, sp and count are unchanged; top keeps its old value.

Test Plan:
- Reset, then push 0x010, 0x020, 0x030 on successive cycles -> count=3, top=0x030, empty=0, full=0.
- From that state, pop three times -> top goes 0x020, 0x010, then 0; count=0; empty=1; underflow=0.
- Pop on an empty stack -> underflow=1, count=0, top=0. Then assert clear_err for one cycle -> underflow=0.
- Push 0x005 then, in one cycle, push=1 with pop=1 and push_addr=0x1FF -> count=1, top=0x1FF.
- Push 0x001..0x008 (full=1), then push 0x0AA:
  - Without the macro: top=0x008, count=8, overflow=1.
  - With RETURNSTACK_WRAP_EN: top=0x0AA, count=8, overflow=1; eight pops yield 0x0AA, 0x008 .. 0x002.
- Push 0x033, assert reset asynchronously between clock edges -> count=0, top=0, flags=0 immediately, without waiting for a clock edge.
